// File: rtl/eth_vlg_strm_chk.sv
// eth_vlg_strm_chk
//   Passive framing checker for N_CH byte streams of the val/sof/eof kind.
//   Each channel runs a small IDLE/FRAME/ABORT tracker. Framing and length
//   violations set sticky per-channel error bits. A saturating counter counts
//   the cycles in which at least one new violation appeared, and the length of
//   the last eof-terminated frame is kept per channel.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_clr        clears o_err_flags and o_err_cnt, frame trackers unaffected
//   i_val        byte valid, one bit per channel
//   i_sof        start of frame, qualified by i_val
//   i_eof        end of frame, qualified by i_val
//   o_err_flags  sticky error bits, channel c at [8c+7:8c]
//                bit 0 SOF_NVAL, 1 EOF_NVAL, 2 SOF_MID, 3 ORPHAN,
//                bit 4 SHORT,    5 LONG,     6 GAP,     7 B2B
//   o_err_any    OR of all error bits
//   o_err_cnt    saturating count of cycles with at least one new violation
//   o_len_last   length of last eof-terminated frame, channel c at [LEN_W*c +: LEN_W]
module eth_vlg_strm_chk #(
  parameter int N_CH        = 4,
  parameter int LEN_W       = 16,
  parameter int CNT_W       = 16,
  parameter int MIN_LEN     = 20,
  parameter int MAX_LEN     = 1500,
  parameter int GAP_ALLOWED = 0,
  parameter int B2B_ALLOWED = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic [N_CH-1:0]         i_val,
  input  logic [N_CH-1:0]         i_sof,
  input  logic [N_CH-1:0]         i_eof,
  output logic [8*N_CH-1:0]       o_err_flags,
  output logic                    o_err_any,
  output logic [CNT_W-1:0]        o_err_cnt,
  output logic [LEN_W*N_CH-1:0]   o_len_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] L_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] L_MIN  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] L_MAX1 = LEN_W'(MAX_LEN + 1);

  state_t             r_state   [N_CH];
  logic [LEN_W-1:0]   r_len     [N_CH];
  logic [LEN_W-1:0]   r_lenLast [N_CH];
  logic [N_CH-1:0]    r_eofPrev;
  logic [8*N_CH-1:0]  r_flags;
  logic [CNT_W-1:0]   r_errCnt;

  state_t             w_nextState   [N_CH];
  logic [LEN_W-1:0]   w_nextLen     [N_CH];
  logic [LEN_W-1:0]   w_nextLenLast [N_CH];
  logic [LEN_W-1:0]   w_lenInc      [N_CH];
  logic [N_CH-1:0]    w_start;
  logic [8*N_CH-1:0]  w_set;
  logic               w_newAny;

  // Per-channel frame tracking. Every state decides whether the current byte
  // opens a new frame (w_start); the frame opening itself, including the
  // single-byte sof+eof case, is handled once after the state decode so that
  // IDLE, FRAME restart and ABORT recovery all behave identically.
  // A byte that would push the length to MAX_LEN+1 aborts the frame even if it
  // also carries eof; in that case the frame ends at once without updating the
  // last length, exactly as an ABORT followed by eof would.
  always_comb begin
    w_start = '0;
    w_set   = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_nextState[c]   = r_state[c];
      w_nextLen[c]     = r_len[c];
      w_nextLenLast[c] = r_lenLast[c];
      w_lenInc[c]      = r_len[c] + L_ONE;

      if (i_sof[c] && !i_val[c]) w_set[8*c+0] = 1'b1;
      if (i_eof[c] && !i_val[c]) w_set[8*c+1] = 1'b1;

      case (r_state[c])
        IDLE: begin
          if (i_val[c]) begin
            if (i_sof[c]) begin
              if (r_eofPrev[c] && (B2B_ALLOWED == 0)) w_set[8*c+7] = 1'b1;
              w_start[c] = 1'b1;
            end else begin
              w_set[8*c+3] = 1'b1;
            end
          end
        end
        FRAME: begin
          if (i_val[c]) begin
            if (i_sof[c]) begin
              w_set[8*c+2] = 1'b1;
              w_start[c]   = 1'b1;
            end else if (w_lenInc[c] == L_MAX1) begin
              w_set[8*c+5] = 1'b1;
              if (i_eof[c]) begin
                w_nextState[c] = IDLE;
                w_nextLen[c]   = '0;
              end else begin
                w_nextState[c] = ABORT;
                w_nextLen[c]   = L_MAX1;
              end
            end else if (i_eof[c]) begin
              w_nextState[c]   = IDLE;
              w_nextLen[c]     = '0;
              w_nextLenLast[c] = w_lenInc[c];
              if (w_lenInc[c] < L_MIN) w_set[8*c+4] = 1'b1;
            end else begin
              w_nextLen[c] = w_lenInc[c];
            end
          end else if (GAP_ALLOWED == 0) begin
            w_set[8*c+6] = 1'b1;
          end
        end
        ABORT: begin
          if (i_val[c]) begin
            if (i_sof[c]) begin
              w_start[c] = 1'b1;
            end else if (i_eof[c]) begin
              w_nextState[c] = IDLE;
              w_nextLen[c]   = '0;
            end
          end
        end
        default: begin
          w_nextState[c] = IDLE;
          w_nextLen[c]   = '0;
        end
      endcase

      if (w_start[c]) begin
        if (i_eof[c]) begin
          w_nextState[c]   = IDLE;
          w_nextLen[c]     = '0;
          w_nextLenLast[c] = L_ONE;
          if (L_ONE < L_MIN) w_set[8*c+4] = 1'b1;
        end else begin
          w_nextState[c] = FRAME;
          w_nextLen[c]   = L_ONE;
        end
      end
    end
  end

  assign w_newAny = |w_set;

  // State, length and error registers. New violations are ORed in after the
  // clear so a bit raised in the clear cycle survives, and the counter restarts
  // at 1 when a clear coincides with a violation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < N_CH; c++) begin
        r_state[c]   <= IDLE;
        r_len[c]     <= '0;
        r_lenLast[c] <= '0;
      end
      r_eofPrev <= '0;
      r_flags   <= '0;
      r_errCnt  <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        r_state[c]   <= w_nextState[c];
        r_len[c]     <= w_nextLen[c];
        r_lenLast[c] <= w_nextLenLast[c];
      end
      r_eofPrev <= i_val & i_eof;
      r_flags   <= (i_clr ? '0 : r_flags) | w_set;
      if (i_clr) begin
        r_errCnt <= w_newAny ? CNT_W'(1) : '0;
      end else if (w_newAny && (r_errCnt != {CNT_W{1'b1}})) begin
        r_errCnt <= r_errCnt + CNT_W'(1);
      end
    end
  end

  // Flatten the per-channel last-length registers onto the output bus.
  for (genvar g = 0; g < N_CH; g++) begin : g_lenOut
    assign o_len_last[LEN_W*g +: LEN_W] = r_lenLast[g];
  end

  assign o_err_flags = r_flags;
  assign o_err_any   = |r_flags;
  assign o_err_cnt   = r_errCnt;

endmodule

// File: tb/tb_eth_vlg_strm_chk.sv
// tb_eth_vlg_strm_chk
//   Directed bench for eth_vlg_strm_chk with default parameters. Each feature
//   has its own task that drives cycles and compares outputs against
//   hand-computed values one #1 after the clock edge.
module tb_eth_vlg_strm_chk;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [3:0]  val;
  logic [3:0]  sof;
  logic [3:0]  eof;
  logic [31:0] errFlags;
  logic        errAny;
  logic [15:0] errCnt;
  logic [63:0] lenLast;

  int checks;
  int errors;

  eth_vlg_strm_chk dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clr       (clr),
    .i_val       (val),
    .i_sof       (sof),
    .i_eof       (eof),
    .o_err_flags (errFlags),
    .o_err_any   (errAny),
    .o_err_cnt   (errCnt),
    .o_len_last  (lenLast)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then move just past the edge for sampling.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] s,
                               input logic [3:0] e, input logic c);
    val = v; sof = s; eof = e; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Send n valid bytes on channel ch, sof on the first, optional eof on the last.
  task automatic sendFrame(input int ch, input int n, input bit withEof);
    logic [3:0] m;
    m = 4'(1 << ch);
    for (int i = 0; i < n; i++)
      applyStimulus(m, (i == 0) ? m : 4'b0, (withEof && i == n - 1) ? m : 4'b0, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(4'b0, 4'b0, 4'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(4'b0, 4'b0, 4'b0, 1'b0);
    applyStimulus(4'b0, 4'b0, 4'b0, 1'b0);
    rst = 1'b0;
    checks++; if (errFlags !== 32'h0) begin errors++; $display("[TB] FAIL reset_flags got=%h exp=%h", errFlags, 32'h0); end
    checks++; if (errAny !== 1'b0) begin errors++; $display("[TB] FAIL reset_any got=%b exp=0", errAny); end
    checks++; if (errCnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d exp=0", errCnt); end
    checks++; if (lenLast !== 64'h0) begin errors++; $display("[TB] FAIL reset_len got=%h exp=0", lenLast); end
  endtask

  task automatic test_clean_frame();
    sendFrame(0, 46, 1'b1);
    checks++; if (errFlags !== 32'h0) begin errors++; $display("[TB] FAIL clean_flags got=%h exp=0", errFlags); end
    checks++; if (lenLast[15:0] !== 16'd46) begin errors++; $display("[TB] FAIL clean_len got=%0d exp=46", lenLast[15:0]); end
    checks++; if (errCnt !== 16'd0) begin errors++; $display("[TB] FAIL clean_cnt got=%0d exp=0", errCnt); end
    applyStimulus(4'b0, 4'b0, 4'b0, 1'b0);
  endtask

  task automatic test_short();
    sendFrame(1, 9, 1'b0);
    checks++; if (errFlags !== 32'h0) begin errors++; $display("[TB] FAIL short_pre got=%h exp=0", errFlags); end
    applyStimulus(4'b0010, 4'b0, 4'b0010, 1'b0);
    checks++; if (errFlags !== 32'h0000_1000) begin errors++; $display("[TB] FAIL short_flags got=%h exp=%h", errFlags, 32'h0000_1000); end
    checks++; if (lenLast[31:16] !== 16'd10) begin errors++; $display("[TB] FAIL short_len got=%0d exp=10", lenLast[31:16]); end
    checks++; if (errCnt !== 16'd1) begin errors++; $display("[TB] FAIL short_cnt got=%0d exp=1", errCnt); end
    applyStimulus(4'b0, 4'b0, 4'b0, 1'b0);
    doClear();
    checks++; if (errFlags !== 32'h0 || errCnt !== 16'd0) begin errors++; $display("[TB] FAIL clear got=%h/%0d exp=0/0", errFlags, errCnt); end
  endtask

  task automatic test_long();
    sendFrame(0, 1500, 1'b0);
    checks++; if (errFlags !== 32'h0) begin errors++; $display("[TB] FAIL long_pre got=%h exp=0", errFlags); end
    applyStimulus(4'b0001, 4'b0, 4'b0, 1'b0);
    checks++; if (errFlags !== 32'h0000_0020) begin errors++; $display("[TB] FAIL long_flags got=%h exp=%h", errFlags, 32'h20); end
    checks++; if (errCnt !== 16'd1) begin errors++; $display("[TB] FAIL long_cnt got=%0d exp=1", errCnt); end
    applyStimulus(4'b0001, 4'b0, 4'b0001, 1'b0);
    applyStimulus(4'b0, 4'b0, 4'b0, 1'b0);
    checks++; if (errFlags !== 32'h0000_0020 || errCnt !== 16'd1) begin errors++; $display("[TB] FAIL abort_eof got=%h/%0d exp=20/1", errFlags, errCnt); end
    checks++; if (lenLast[15:0] !== 16'd46) begin errors++; $display("[TB] FAIL abort_len got=%0d exp=46", lenLast[15:0]); end
    doClear();
  endtask

  task automatic test_nval();
    applyStimulus(4'b0, 4'b0100, 4'b1000, 1'b0);
    checks++; if (errFlags !== 32'h0201_0000) begin errors++; $display("[TB] FAIL nval_flags got=%h exp=%h", errFlags, 32'h0201_0000); end
    checks++; if (errCnt !== 16'd1) begin errors++; $display("[TB] FAIL nval_cnt got=%0d exp=1", errCnt); end
    checks++; if (errAny !== 1'b1) begin errors++; $display("[TB] FAIL nval_any got=%b exp=1", errAny); end
    doClear();
  endtask

  task automatic test_back_to_back();
    sendFrame(0, 11, 1'b1);
    checks++; if (errFlags !== 32'h10 || errCnt !== 16'd1) begin errors++; $display("[TB] FAIL b2b_short got=%h/%0d exp=10/1", errFlags, errCnt); end
    applyStimulus(4'b0001, 4'b0001, 4'b0, 1'b0);
    checks++; if (errFlags !== 32'h90 || errCnt !== 16'd2) begin errors++; $display("[TB] FAIL b2b_flags got=%h/%0d exp=90/2", errFlags, errCnt); end
    checks++; if (lenLast[15:0] !== 16'd11) begin errors++; $display("[TB] FAIL b2b_len got=%0d exp=11", lenLast[15:0]); end
    for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 4'b0, 4'b0, 1'b0);
    applyStimulus(4'b0, 4'b0, 4'b0, 1'b0);
    checks++; if (errFlags !== 32'hD0 || errCnt !== 16'd3) begin errors++; $display("[TB] FAIL gap_flags got=%h/%0d exp=d0/3", errFlags, errCnt); end
    for (int i = 0; i < 19; i++) applyStimulus(4'b0001, 4'b0, 4'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0, 4'b0001, 1'b0);
    checks++; if (lenLast[15:0] !== 16'd25) begin errors++; $display("[TB] FAIL gap_len got=%0d exp=25", lenLast[15:0]); end
    checks++; if (errFlags !== 32'hD0 || errCnt !== 16'd3) begin errors++; $display("[TB] FAIL gap_end got=%h/%0d exp=d0/3", errFlags, errCnt); end
    applyStimulus(4'b0, 4'b0, 4'b0, 1'b0);
    doClear();
  endtask

  task automatic test_single_byte();
    applyStimulus(4'b1000, 4'b1000, 4'b1000, 1'b0);
    checks++; if (lenLast[63:48] !== 16'd1) begin errors++; $display("[TB] FAIL single_len got=%0d exp=1", lenLast[63:48]); end
    checks++; if (errFlags !== 32'h1000_0000 || errCnt !== 16'd1) begin errors++; $display("[TB] FAIL single_flags got=%h/%0d exp=10000000/1", errFlags, errCnt); end
    applyStimulus(4'b0, 4'b0, 4'b0, 1'b0);
    doClear();
  endtask

  task automatic test_clr_and_reset();
    applyStimulus(4'b0, 4'b0001, 4'b0, 1'b0);
    checks++; if (errFlags !== 32'h1 || errCnt !== 16'd1) begin errors++; $display("[TB] FAIL pre_clr got=%h/%0d exp=1/1", errFlags, errCnt); end
    applyStimulus(4'b0010, 4'b0, 4'b0, 1'b1);
    checks++; if (errFlags !== 32'h0000_0800) begin errors++; $display("[TB] FAIL clr_set_flags got=%h exp=%h", errFlags, 32'h800); end
    checks++; if (errCnt !== 16'd1) begin errors++; $display("[TB] FAIL clr_set_cnt got=%0d exp=1", errCnt); end
    doClear();
    applyStimulus(4'b0001, 4'b0001, 4'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0, 4'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(4'b0, 4'b0, 4'b0, 1'b0);
    rst = 1'b0;
    checks++; if (errFlags !== 32'h0 || errCnt !== 16'd0 || lenLast !== 64'h0) begin errors++; $display("[TB] FAIL midrst got=%h/%0d/%h exp=0/0/0", errFlags, errCnt, lenLast); end
    applyStimulus(4'b0001, 4'b0, 4'b0, 1'b0);
    checks++; if (errFlags !== 32'h8 || errCnt !== 16'd1) begin errors++; $display("[TB] FAIL orphan1 got=%h/%0d exp=8/1", errFlags, errCnt); end
    applyStimulus(4'b0001, 4'b0, 4'b0001, 1'b0);
    checks++; if (errFlags !== 32'h8 || errCnt !== 16'd2) begin errors++; $display("[TB] FAIL orphan2 got=%h/%0d exp=8/2", errFlags, errCnt); end
    checks++; if (lenLast !== 64'h0) begin errors++; $display("[TB] FAIL orphan_len got=%h exp=0", lenLast); end
  endtask

  // Run all scenarios in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; clr = 1'b0; val = '0; sof = '0; eof = '0;
    test_reset();
    test_clean_frame();
    test_short();
    test_long();
    test_nval();
    test_back_to_back();
    test_single_byte();
    test_clr_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
